pipe_reg_chain: RTL and testbench
=================================

// Module: pipe_reg_chain
// PURPOSE
//  Parametrised chain of DEPTH pipeline registers with valid/ready handshake,
//  per-stage flush, global hold and optional bubble collapsing. It generalises
//  the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers, with their hold, busywait
//  and hazard-reset behaviour, into one reusable block. The target is the
//  deeper-pipeline and extension cores, where stage count and payload width vary.
// PARAMETERS
//  WIDTH       32            payload bits per stage
//  DEPTH       3             number of register stages (>=1)
//  COLLAPSE    1             1: a stalled chain absorbs bubbles; 0: rigid lock-step advance
//  BUBBLE_VAL  32'h00000013  payload written on reset/flush (RV32 NOP); sized WIDTH
// PORTS
//  CLK          in   1               clock, rising edge
//  RESET        in   1               asynchronous, active-high
//  IN_VALID     in   1               upstream presents IN_DATA
//  IN_DATA      in   WIDTH           upstream payload
//  IN_READY     out  1               stage 0 accepts this cycle
//  OUT_VALID    out  1               stage DEPTH-1 holds valid payload
//  OUT_DATA     out  WIDTH           stage DEPTH-1 payload
//  OUT_READY    in   1               downstream consumes this cycle
//  HOLD         in   1               global freeze (memory busywait)
//  FLUSH        in   DEPTH           FLUSH[i] kills stage i content at next edge
//  STAGE_VALID  out  DEPTH           registered valid bit per stage
//  OCCUPANCY    out  $clog2(DEPTH+1) popcount of STAGE_VALID
// BEHAVIOUR
//  - Reset (async): all valid=0, all data=BUBBLE_VAL; so OUT_VALID=0,
//    OUT_DATA=BUBBLE_VAL, OCCUPANCY=0, IN_READY=1 once RESET drops (HOLD=0).
//  - Reset mid-operation discards all in-flight payloads immediately. No output
//    glitches to a stale valid.
//  - rdy[DEPTH] = OUT_READY.
//  - COLLAPSE=1: rdy[i] = !v[i] | rdy[i+1].
//  - COLLAPSE=0: rdy[i] = rdy[DEPTH] for all i.
//  - IN_READY = rdy[0] & !HOLD. It is combinational; there is no path from
//    IN_VALID to IN_READY.
//  - Source of stage i: src_v = (i==0 ? IN_VALID : v[i-1] & !FLUSH[i-1]).
//    src_d is the matching data.
//  - Per-edge priority for each stage i, in this order:
//    1. FLUSH[i]: v<=0, d<=BUBBLE_VAL.
//    2. HOLD: no change.
//    3. rdy[i]: v<=src_v, d<=src_v ? src_d : BUBBLE_VAL.
//    4. otherwise: no change.
//  - Flush wins over HOLD. A payload moving into a flushed stage is dropped.
//    A flushed stage never forwards its content.
//  - Transfer out happens when OUT_VALID & OUT_READY & !HOLD & !FLUSH[DEPTH-1].
//  - Latency is exactly DEPTH cycles from IN_VALID&IN_READY to OUT_VALID, with
//    no stalls. Throughput is 1 per cycle.
//  - Full, COLLAPSE=1: all v=1 & !OUT_READY gives IN_READY=0.
//  - Empty: OUT_VALID=0; OUT_READY is ignored.
//  - DEPTH=1 is a single skid-less register: IN_READY = !v | OUT_READY.
//  - OCCUPANCY is combinational from the registered valid bits and is never
//    greater than DEPTH.
// TESTING
//  - Reset: assert RESET mid-stream, DEPTH=3 -> STAGE_VALID=3'b000,
//    OUT_DATA=0x00000013, OCCUPANCY=0, with no clock edge required.
//  - Stream: IN_DATA=1,2,3,4 on consecutive cycles, OUT_READY=1 ->
//    OUT_DATA=1..4 on cycles 3..6, IN_READY stays 1.
//  - Backpressure, COLLAPSE=1: fill with 0xA,0xB, then drop OUT_READY for
//    4 cycles -> chain fills to OCCUPANCY=3 and IN_READY=0. Release ->
//    order preserved.
//  - Rigid, COLLAPSE=0: same stimulus -> IN_READY=0 as soon as OUT_READY=0,
//    and the bubble in stage 1 persists.
//  - Flush: payloads 0x10,0x20,0x30 in stages 0..2, FLUSH=3'b011 ->
//    next edge only 0x30 remains valid. Stages 0 and 1 hold 0x13, and an
//    IN_DATA accepted that cycle is dropped.
//  - HOLD+FLUSH: HOLD=1 for 3 cycles with FLUSH[2]=1 in cycle 2 ->
//    stage 2 is invalidated, stages 0 and 1 are frozen, and nothing is lost
//    after HOLD drops.

Source files
------------

// File: rtl/pipe_reg_chain_if.sv
// ============================================================================
//  Module      : pipe_reg_chain_if
//  Description : Handshake, control and status bundle for pipe_reg_chain.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_reg_chain_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             hold;
    logic [DEPTH-1:0] flush;
    logic [DEPTH-1:0] stage_valid;
    logic [OCC_W-1:0] occupancy;

    // master: the side that feeds the chain, sinks its output and controls it
    modport master (
        output in_valid, in_data, out_ready, hold, flush,
        input  in_ready, out_valid, out_data, stage_valid, occupancy
    );

    modport slave (
        input  in_valid, in_data, out_ready, hold, flush,
        output in_ready, out_valid, out_data, stage_valid, occupancy
    );
endinterface

`default_nettype wire

// File: rtl/pipe_reg_chain.sv
// ============================================================================
//  Module      : pipe_reg_chain
//  Description : DEPTH-stage valid/ready register chain with per-stage flush,
//                global hold and optional bubble collapsing.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_reg_chain #(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH      = 3,
    parameter int               COLLAPSE   = 1,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(32'h0000_0013)
) (
    input  wire logic       clk,
    input  wire logic       rst,
    pipe_reg_chain_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];

    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d [DEPTH];
    logic [OCC_W-1:0] occ;

    // Ready is built from the output end backwards with a running term so the
    // rdy vector never depends on itself.
    always_comb begin
        logic acc;
        rdy        = '0;
        acc        = bus.out_ready;
        rdy[DEPTH] = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (COLLAPSE != 0) begin
                acc = !valid_q[i] | acc;
            end else begin
                acc = bus.out_ready;
            end
            rdy[i] = acc;
        end
    end

    // A stage being flushed this edge never hands its content downstream.
    always_comb begin
        src_v    = '0;
        src_v[0] = bus.in_valid;
        src_d[0] = bus.in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = valid_q[i-1] & !bus.flush[i-1];
            src_d[i] = data_q[i-1];
        end
    end

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
            if (bus.flush[i]) begin
                valid_d[i] = 1'b0;
                data_d[i]  = BUBBLE_VAL;
            end else if (bus.hold) begin
                valid_d[i] = valid_q[i];
            end else if (rdy[i]) begin
                valid_d[i] = src_v[i];
                data_d[i]  = src_v[i] ? src_d[i] : BUBBLE_VAL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= BUBBLE_VAL;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + OCC_W'(valid_q[i]);
        end
    end

    assign bus.in_ready    = rdy[0] & !bus.hold;
    assign bus.out_valid   = valid_q[DEPTH-1];
    assign bus.out_data    = data_q[DEPTH-1];
    assign bus.stage_valid = valid_q;
    assign bus.occupancy   = occ;

endmodule

`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
// ============================================================================
//  Module      : tb_pipe_reg_chain
//  Description : Directed vector bench for pipe_reg_chain (collapsing, rigid
//                and single-stage variants).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_reg_chain;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic clk;
    logic rst;

    pipe_reg_chain_if #(.WIDTH(32), .DEPTH(3)) col_if ();
    pipe_reg_chain_if #(.WIDTH(32), .DEPTH(3)) rig_if ();
    pipe_reg_chain_if #(.WIDTH(32), .DEPTH(1)) d1_if ();

    pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .COLLAPSE(1)) u_col (
        .clk (clk),
        .rst (rst),
        .bus (col_if)
    );

    pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .COLLAPSE(0)) u_rig (
        .clk (clk),
        .rst (rst),
        .bus (rig_if)
    );

    pipe_reg_chain #(.WIDTH(32), .DEPTH(1), .COLLAPSE(1)) u_d1 (
        .clk (clk),
        .rst (rst),
        .bus (d1_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          rst_b;
        bit          rig;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        hold;
        logic [2:0]  fl;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [2:0]  e_sv;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(bit rb, bit rig, logic iv, logic [31:0] id, logic ordy,
                                logic hold, logic [2:0] fl, logic ir, logic ov,
                                logic [31:0] od, logic [2:0] sv, logic [1:0] occ);
        vec_t v;
        v.rst_b = rb;  v.rig  = rig; v.iv   = iv;  v.id   = id;  v.ordy  = ordy;
        v.hold  = hold; v.fl  = fl;  v.e_ir = ir;  v.e_ov = ov;  v.e_od  = od;
        v.e_sv  = sv;  v.e_occ = occ;
        return v;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h want %h", nm, k, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] id, input logic ordy,
                         input logic hold, input logic [2:0] fl);
        col_if.in_valid = iv;  col_if.in_data = id;  col_if.out_ready = ordy;
        col_if.hold     = hold; col_if.flush  = fl;
        rig_if.in_valid = iv;  rig_if.in_data = id;  rig_if.out_ready = ordy;
        rig_if.hold     = hold; rig_if.flush  = fl;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 3'b000);
        d1_if.in_valid = 1'b0; d1_if.in_data = 32'h0; d1_if.out_ready = 1'b0;
        d1_if.hold     = 1'b0; d1_if.flush   = 1'b0;

        // stream
        tbl.push_back(mk(1,0, 1,32'h1,1,0,3'b000, 1,0,C_NOP,3'b000,0));
        tbl.push_back(mk(0,0, 1,32'h2,1,0,3'b000, 1,0,C_NOP,3'b001,1));
        tbl.push_back(mk(0,0, 1,32'h3,1,0,3'b000, 1,0,C_NOP,3'b011,2));
        tbl.push_back(mk(0,0, 1,32'h4,1,0,3'b000, 1,1,32'h1,3'b111,3));
        tbl.push_back(mk(0,0, 0,32'h0,1,0,3'b000, 1,1,32'h2,3'b111,3));
        tbl.push_back(mk(0,0, 0,32'h0,1,0,3'b000, 1,1,32'h3,3'b110,2));
        tbl.push_back(mk(0,0, 0,32'h0,1,0,3'b000, 1,1,32'h4,3'b100,1));
        tbl.push_back(mk(0,0, 0,32'h0,1,0,3'b000, 1,0,C_NOP,3'b000,0));
        // backpressure with bubble absorption
        tbl.push_back(mk(0,0, 1,32'hA,1,0,3'b000, 1,0,C_NOP,3'b000,0));
        tbl.push_back(mk(0,0, 1,32'hB,1,0,3'b000, 1,0,C_NOP,3'b001,1));
        tbl.push_back(mk(0,0, 1,32'hC,0,0,3'b000, 1,0,C_NOP,3'b011,2));
        for (int j = 0; j < 3; j++)
            tbl.push_back(mk(0,0, 1,32'hD,0,0,3'b000, 0,1,32'hA,3'b111,3));
        tbl.push_back(mk(0,0, 1,32'hD,1,0,3'b000, 1,1,32'hA,3'b111,3));
        tbl.push_back(mk(0,0, 0,32'h0,1,0,3'b000, 1,1,32'hB,3'b111,3));
        tbl.push_back(mk(0,0, 0,32'h0,1,0,3'b000, 1,1,32'hC,3'b110,2));
        tbl.push_back(mk(0,0, 0,32'h0,1,0,3'b000, 1,1,32'hD,3'b100,1));
        tbl.push_back(mk(0,0, 0,32'h0,1,0,3'b000, 1,0,C_NOP,3'b000,0));
        // flush of stages 0 and 1, then flush of an accepted input
        tbl.push_back(mk(0,0, 1,32'h30,1,0,3'b000, 1,0,C_NOP,3'b000,0));
        tbl.push_back(mk(0,0, 1,32'h20,1,0,3'b000, 1,0,C_NOP,3'b001,1));
        tbl.push_back(mk(0,0, 1,32'h10,1,0,3'b000, 1,0,C_NOP,3'b011,2));
        tbl.push_back(mk(0,0, 1,32'h99,0,0,3'b011, 0,1,32'h30,3'b111,3));
        tbl.push_back(mk(0,0, 0,32'h0,0,0,3'b000, 1,1,32'h30,3'b100,1));
        tbl.push_back(mk(0,0, 1,32'h55,0,0,3'b001, 1,1,32'h30,3'b100,1));
        tbl.push_back(mk(0,0, 0,32'h0,1,0,3'b000, 1,1,32'h30,3'b100,1));
        tbl.push_back(mk(0,0, 0,32'h0,1,0,3'b000, 1,0,C_NOP,3'b000,0));
        // hold with a flush of the last stage in its middle cycle
        tbl.push_back(mk(0,0, 1,32'h41,1,0,3'b000, 1,0,C_NOP,3'b000,0));
        tbl.push_back(mk(0,0, 1,32'h42,1,0,3'b000, 1,0,C_NOP,3'b001,1));
        tbl.push_back(mk(0,0, 1,32'h43,1,0,3'b000, 1,0,C_NOP,3'b011,2));
        tbl.push_back(mk(0,0, 1,32'h44,1,1,3'b000, 0,1,32'h41,3'b111,3));
        tbl.push_back(mk(0,0, 1,32'h44,1,1,3'b100, 0,1,32'h41,3'b111,3));
        tbl.push_back(mk(0,0, 1,32'h44,1,1,3'b000, 0,0,C_NOP,3'b011,2));
        tbl.push_back(mk(0,0, 0,32'h0,1,0,3'b000, 1,0,C_NOP,3'b011,2));
        tbl.push_back(mk(0,0, 0,32'h0,1,0,3'b000, 1,1,32'h42,3'b110,2));
        tbl.push_back(mk(0,0, 0,32'h0,1,0,3'b000, 1,1,32'h43,3'b100,1));
        tbl.push_back(mk(0,0, 0,32'h0,1,0,3'b000, 1,0,C_NOP,3'b000,0));
        // rigid chain: bubble in stage 1 survives the stall
        tbl.push_back(mk(1,1, 1,32'hA,1,0,3'b000, 1,0,C_NOP,3'b000,0));
        tbl.push_back(mk(0,1, 0,32'h0,1,0,3'b000, 1,0,C_NOP,3'b001,1));
        tbl.push_back(mk(0,1, 1,32'hB,1,0,3'b000, 1,0,C_NOP,3'b010,1));
        for (int j = 0; j < 4; j++)
            tbl.push_back(mk(0,1, 1,32'hC,0,0,3'b000, 0,1,32'hA,3'b101,2));
        tbl.push_back(mk(0,1, 0,32'h0,1,0,3'b000, 1,1,32'hA,3'b101,2));
        tbl.push_back(mk(0,1, 0,32'h0,1,0,3'b000, 1,0,C_NOP,3'b010,1));
        tbl.push_back(mk(0,1, 0,32'h0,1,0,3'b000, 1,1,32'hB,3'b100,1));
        tbl.push_back(mk(0,1, 0,32'h0,1,0,3'b000, 1,0,C_NOP,3'b000,0));

        // state while reset is held, before any clock edge
        #1;
        chk("rst_sv",  0, 32'(col_if.stage_valid), 32'h0);
        chk("rst_od",  0, col_if.out_data, C_NOP);
        chk("rst_occ", 0, 32'(col_if.occupancy), 32'h0);
        chk("rst_ov",  0, 32'(col_if.out_valid), 32'h0);

        @(posedge clk); #1;
        for (int k = 0; k < tbl.size(); k++) begin
            vec_t v;
            v = tbl[k];
            if (v.rst_b) begin
                rst = 1'b1;
                #2;
                rst = 1'b0;
            end
            drive(v.iv, v.id, v.ordy, v.hold, v.fl);
            @(negedge clk);
            if (v.rig) begin
                chk("ir",  k, 32'(rig_if.in_ready),    32'(v.e_ir));
                chk("ov",  k, 32'(rig_if.out_valid),   32'(v.e_ov));
                chk("od",  k, rig_if.out_data,         v.e_od);
                chk("sv",  k, 32'(rig_if.stage_valid), 32'(v.e_sv));
                chk("occ", k, 32'(rig_if.occupancy),   32'(v.e_occ));
            end else begin
                chk("ir",  k, 32'(col_if.in_ready),    32'(v.e_ir));
                chk("ov",  k, 32'(col_if.out_valid),   32'(v.e_ov));
                chk("od",  k, col_if.out_data,         v.e_od);
                chk("sv",  k, 32'(col_if.stage_valid), 32'(v.e_sv));
                chk("occ", k, 32'(col_if.occupancy),   32'(v.e_occ));
            end
            @(posedge clk); #1;
        end

        // asynchronous reset with two payloads in flight
        drive(1'b1, 32'h1, 1'b1, 1'b0, 3'b000);
        @(posedge clk); #1;
        drive(1'b1, 32'h2, 1'b1, 1'b0, 3'b000);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 3'b000);
        chk("mid_pre_sv", 0, 32'(col_if.stage_valid), 32'h3);
        #2 rst = 1'b1;
        #1;
        chk("mid_sv",     0, 32'(col_if.stage_valid), 32'h0);
        chk("mid_od",     0, col_if.out_data, C_NOP);
        chk("mid_occ",    0, 32'(col_if.occupancy), 32'h0);
        chk("mid_rig_sv", 0, 32'(rig_if.stage_valid), 32'h0);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // single-stage chain
        d1_if.in_valid = 1'b0; d1_if.out_ready = 1'b0;
        #1;
        chk("d1_empty_ir", 0, 32'(d1_if.in_ready), 32'h1);
        d1_if.in_valid = 1'b1; d1_if.in_data = 32'h77;
        @(posedge clk); #1;
        d1_if.in_valid = 1'b0;
        @(negedge clk);
        chk("d1_ov",      0, 32'(d1_if.out_valid), 32'h1);
        chk("d1_od",      0, d1_if.out_data, 32'h77);
        chk("d1_full_ir", 0, 32'(d1_if.in_ready), 32'h0);
        d1_if.out_ready = 1'b1;
        #1;
        chk("d1_drain_ir", 0, 32'(d1_if.in_ready), 32'h1);
        @(posedge clk); #1;
        d1_if.out_ready = 1'b0;
        @(negedge clk);
        chk("d1_after_ov", 0, 32'(d1_if.out_valid), 32'h0);
        chk("d1_after_od", 0, d1_if.out_data, C_NOP);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
